// File: rtl/band_scale_seq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared types and constants for the band-gain sequencer (band_scale_seq).
//   state_t  : sequencer FSM states
//   AUD_W    : audio sample width (signed)
//   POT_W    : slider / gain width (unsigned)
//   PROD_W   : width of the signed gain x audio product
//   SAT_POS  : positive full-scale audio code
//   SAT_NEG  : negative full-scale audio code
// -----------------------------------------------------------------------------
package eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int AUD_W  = 16;
    localparam int POT_W  = 12;
    localparam int PROD_W = AUD_W + POT_W + 1;

    localparam logic [AUD_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [AUD_W-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/band_scale_seq_if.sv
// -----------------------------------------------------------------------------
// band_scale_seq_if
// Sample handshake bundle between the FIR band filters / output stage and the
// band-gain sequencer.
//   vld        : one-cycle pulse, band_audio and pot valid
//   band_audio : NUM_BANDS x 16-bit signed band samples, band 0 in LSBs
//   pot        : NUM_BANDS x 12-bit unsigned slider values, band 0 in LSBs
//   busy       : sample in flight
//   aud_out    : signed equalized sample, held until the next result
//   aud_vld    : one-cycle pulse, aud_out updated
//   ovr        : sticky, vld arrived while busy
// master = sample source/sink side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface band_scale_seq_if #(
    parameter int NUM_BANDS = 5
);
    import eq_pkg::*;

    logic                         vld;
    logic [NUM_BANDS*AUD_W-1:0]   band_audio;
    logic [NUM_BANDS*POT_W-1:0]   pot;
    logic                         busy;
    logic [AUD_W-1:0]             aud_out;
    logic                         aud_vld;
    logic                         ovr;

    modport master (
        output vld, band_audio, pot,
        input  busy, aud_out, aud_vld, ovr
    );

    modport slave (
        input  vld, band_audio, pot,
        output busy, aud_out, aud_vld, ovr
    );

endinterface

// File: rtl/band_scale_seq_band_gain_sat.sv
// -----------------------------------------------------------------------------
// band_gain_sat
// Combinational per-band gain stage: multiplies a 12-bit unsigned gain by a
// 16-bit signed audio sample and returns a saturated 16-bit band result
// (product scaled down by 2^10).
//   gain     in  12-bit unsigned gain (pot squared, upper half)
//   audio    in  16-bit signed band sample
//   band_res out 16-bit signed saturated band result
// -----------------------------------------------------------------------------
module band_gain_sat
    import eq_pkg::*;
(
    input  logic        [POT_W-1:0] gain,
    input  logic signed [AUD_W-1:0] audio,
    output logic signed [AUD_W-1:0] band_res
);

    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] audio_ext;
    logic signed [PROD_W-1:0] prod;
    logic        [2:0]        guard;

    always_comb begin
        gain_ext  = {{(PROD_W-POT_W){1'b0}}, gain};
        audio_ext = {{(PROD_W-AUD_W){audio[AUD_W-1]}}, audio};
        // Full product of a 13-bit non-negative and a 16-bit signed operand
        // always fits in PROD_W bits, so the truncated multiply is exact.
        prod      = gain_ext * audio_ext;
        guard     = prod[27:25];

        // The kept slice is prod[25:10]; bits 28:25 must all match the sign
        // for that slice to represent the scaled value without wrap.
        if (!prod[28] && (guard != 3'b000)) begin
            band_res = SAT_POS;
        end else if (prod[28] && (guard != 3'b111)) begin
            band_res = SAT_NEG;
        end else begin
            band_res = prod[25:10];
        end
    end

endmodule

// File: rtl/band_scale_seq.sv
// -----------------------------------------------------------------------------
// band_scale_seq
// Time-multiplexed band-gain sequencer. One squarer and one gain multiplier
// are shared across NUM_BANDS bands: each band gets gain = (pot^2)[23:12],
// is scaled and saturated to 16 bits, and the bands are summed into one
// saturated 16-bit equalized sample. Started once per audio sample by vld.
//
// Ports:
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : band_scale_seq_if.slave (vld/band_audio/pot in, busy/aud_out/
//         aud_vld/ovr out)
//
// States:
//   ST_IDLE  | waiting for vld; vld captures inputs, clears acc and counter
//   ST_RUN   | stage 1 squares pot[cnt]; stage 2 accumulates band cnt-1
//   ST_FLUSH | stage 2 accumulates the last band
//   ST_OUT   | clamp accumulator into aud_out, pulse aud_vld
// -----------------------------------------------------------------------------
module band_scale_seq
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 5,
    parameter int ACC_W     = AUD_W + $clog2(NUM_BANDS)
) (
    input  logic              clk,
    input  logic              rst,
    band_scale_seq_if.slave   bus
);

    localparam int              CNT_W     = $clog2(NUM_BANDS);
    localparam logic [CNT_W-1:0] LAST_BAND = CNT_W'(NUM_BANDS - 1);

    state_t state;
    state_t state_nxt;

    logic capture;
    logic run_step;
    logic emit;

    logic        [AUD_W-1:0]   aud_r [NUM_BANDS];
    logic        [POT_W-1:0]   pot_r [NUM_BANDS];
    logic        [CNT_W-1:0]   cnt;
    logic        [POT_W-1:0]   gain_r;
    logic        [CNT_W-1:0]   gain_idx;
    logic                      s2_vld;
    logic signed [ACC_W-1:0]   acc;
    logic        [AUD_W-1:0]   aud_out_r;
    logic                      aud_vld_r;
    logic                      ovr_r;

    logic        [2*POT_W-1:0] pot_sq;
    logic signed [AUD_W-1:0]   band_res;
    logic        [AUD_W-1:0]   acc_clamped;
    logic        [ACC_W-AUD_W:0] acc_top;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        run_step  = 1'b0;
        emit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.vld) begin
                    capture   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                run_step = 1'b1;
                if (cnt == LAST_BAND) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                emit      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- shared datapath
    always_comb begin
        pot_sq = {{POT_W{1'b0}}, pot_r[cnt]} * {{POT_W{1'b0}}, pot_r[cnt]};
    end

    band_gain_sat u_band_gain_sat (
        .gain     (gain_r),
        .audio    ($signed(aud_r[gain_idx])),
        .band_res (band_res)
    );

    // Accumulator fits in 16 bits exactly when all bits from 15 upward agree.
    always_comb begin
        acc_top = acc[ACC_W-1:AUD_W-1];
        if ((acc_top == '0) || (acc_top == '1)) begin
            acc_clamped = acc[AUD_W-1:0];
        end else if (acc[ACC_W-1]) begin
            acc_clamped = SAT_NEG;
        end else begin
            acc_clamped = SAT_POS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                aud_r[b] <= '0;
                pot_r[b] <= '0;
            end
            cnt       <= '0;
            gain_r    <= '0;
            gain_idx  <= '0;
            s2_vld    <= 1'b0;
            acc       <= '0;
            aud_out_r <= '0;
            aud_vld_r <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            if (capture) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    aud_r[b] <= bus.band_audio[b*AUD_W +: AUD_W];
                    pot_r[b] <= bus.pot[b*POT_W +: POT_W];
                end
                cnt <= '0;
                acc <= '0;
            end

            // Stage 1: square this band's pot; stage 2 sees it next cycle.
            s2_vld <= run_step;
            if (run_step) begin
                gain_r   <= pot_sq[2*POT_W-1:POT_W];
                gain_idx <= cnt;
                cnt      <= cnt + CNT_W'(1);
            end

            // Stage 2: accumulate the previous band's saturated result.
            if (s2_vld) begin
                acc <= acc + {{(ACC_W-AUD_W){band_res[AUD_W-1]}}, band_res};
            end

            aud_vld_r <= emit;
            if (emit) begin
                aud_out_r <= acc_clamped;
            end

            if (bus.vld && (state != ST_IDLE)) begin
                ovr_r <= 1'b1;
            end
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.aud_out = aud_out_r;
    assign bus.aud_vld = aud_vld_r;
    assign bus.ovr     = ovr_r;

endmodule

// File: tb/tb_band_scale_seq.sv
// -----------------------------------------------------------------------------
// tb_band_scale_seq
// Self-checking bench for band_scale_seq. Stimulus pushes the expected sample
// and its arrival cycle into a queue; a monitor pops and compares whenever
// aud_vld is seen, and also tracks busy/ovr against a cycle-level model.
// -----------------------------------------------------------------------------
module tb_band_scale_seq;
    import eq_pkg::*;

    localparam int NB  = 5;
    // Negedges from the one that drives vld to the one where aud_vld is seen.
    localparam int LAT = NB + 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    band_scale_seq_if #(.NUM_BANDS(NB)) bus ();

    band_scale_seq #(.NUM_BANDS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc     = 0;
    int          errors  = 0;
    int          checks  = 0;
    bit          model_active = 1'b0;
    int          last_acc     = 0;
    bit          model_ovr    = 1'b0;
    int          ovr_cyc      = 0;
    logic [15:0] stim_aud [NB];
    logic [11:0] stim_pot [NB];

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------ reference model
    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [15:0] ref_sample();
        longint sum = 0;
        for (int b = 0; b < NB; b++) begin
            longint gain;
            longint prod;
            gain = (longint'(stim_pot[b]) * longint'(stim_pot[b])) / 4096;
            prod = gain * longint'($signed(stim_aud[b]));
            sum += clamp16(prod >>> 10);
        end
        return 16'(clamp16(sum));
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------ stimulus
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] a, input logic [11:0] p);
        for (int b = 0; b < NB; b++) begin
            stim_aud[b] = a;
            stim_pot[b] = p;
        end
    endtask

    task automatic rnd_stim();
        for (int b = 0; b < NB; b++) begin
            stim_pot[b] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            stim_aud[b] = 16'($urandom);
        end
    endtask

    // Called on a negedge; returns on the following negedge.
    task automatic send();
        for (int b = 0; b < NB; b++) begin
            bus.band_audio[b*16 +: 16] = stim_aud[b];
            bus.pot[b*12 +: 12]        = stim_pot[b];
        end
        bus.vld = 1'b1;
        if (!model_active || cyc >= last_acc + LAT) begin
            model_active = 1'b1;
            last_acc     = cyc;
            exp_q.push_back('{ref_sample(), cyc + LAT});
        end else if (!model_ovr) begin
            model_ovr = 1'b1;
            ovr_cyc   = cyc + 1;
        end
        @(negedge clk);
        bus.vld        = 1'b0;
        bus.band_audio = 80'({$urandom, $urandom, $urandom});
        bus.pot        = 60'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        model_active = 1'b0;
        model_ovr    = 1'b0;
        @(negedge clk);
        #2;
        check("rst_aud_out", bus.aud_out, 0);
        check("rst_aud_vld", bus.aud_vld, 0);
        check("rst_busy",    bus.busy,    0);
        check("rst_ovr",     bus.ovr,     0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------- monitor
    always begin
        @(negedge clk);
        #1;
        check("busy", bus.busy,
              (model_active && cyc >= last_acc + 1 && cyc <= last_acc + LAT - 1) ? 1 : 0);
        check("ovr", bus.ovr, (model_ovr && cyc >= ovr_cyc) ? 1 : 0);
        if (bus.aud_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_aud_vld", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("aud_out", bus.aud_out, mon_e.val);
                check("latency_cycle", cyc, mon_e.cyc);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            check("missing_aud_vld", 0, 1);
            void'(exp_q.pop_front());
        end
    end

    // ---------------------------------------------------------------- main
    initial begin
        bus.vld        = 1'b0;
        bus.band_audio = '0;
        bus.pot        = '0;
        rst            = 1'b1;
        do_reset();

        // single-band gain
        fill(16'h1234, 12'h000);
        stim_pot[2] = 12'h800;
        stim_aud[2] = 16'hE0C0;
        send();
        idle(LAT);
        check("single_band", bus.aud_out, 16'hE0C0);

        // final-sum saturation
        fill(16'h1000, 12'hFFF);
        send();
        idle(LAT);
        check("sum_sat_pos", bus.aud_out, 16'h7FFF);

        // per-band saturation, both polarities
        fill(16'h0000, 12'h000);
        stim_pot[1] = 12'hFFF;
        stim_aud[1] = 16'h7FFF;
        send();
        idle(LAT);
        check("band_sat_pos", bus.aud_out, 16'h7FFF);
        stim_aud[1] = 16'h8000;
        send();
        idle(LAT);
        check("band_sat_neg", bus.aud_out, 16'h8000);

        // overrun: second vld 3 cycles after the first is dropped
        rnd_stim();
        send();
        idle(2);
        rnd_stim();
        send();
        idle(LAT);
        check("ovr_sticky", bus.ovr, 1);

        // back-to-back: vld in the aud_vld cycle
        rnd_stim();
        send();
        idle(LAT - 1);
        rnd_stim();
        send();
        idle(LAT);

        // mid-operation reset, then normal sample
        rnd_stim();
        send();
        idle(2);
        do_reset();
        fill(16'h1234, 12'h000);
        stim_pot[2] = 12'h800;
        stim_aud[2] = 16'hE0C0;
        send();
        idle(LAT);
        check("after_rst", bus.aud_out, 16'hE0C0);

        // randomized traffic with random gaps (some overruns)
        repeat (40) begin
            rnd_stim();
            send();
            idle($urandom_range(0, LAT + 2));
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
